// File: rtl/gen_pic_sprite_if.sv
// ---------------------------------------------------------------------------
// gen_pic_sprite_if
// Sprite ROM read bus between the sprite engine and its pixel ROM.
//   rom_addr : registered read address driven by the engine
//   rom_data : RGB444 word returned by the ROM, ROM_LAT cycles after rom_addr
// Modports:
//   master : sprite engine (drives rom_addr, receives rom_data)
//   slave  : sprite ROM    (receives rom_addr, drives rom_data)
// ---------------------------------------------------------------------------
interface gen_pic_sprite_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/gen_pic_sprite.sv
// ---------------------------------------------------------------------------
// gen_pic_sprite
// Sprite pixel engine for the VGA path. Tests whether the scan position lies
// inside an SPR_W x SPR_H sprite whose right/bottom (exclusive) edge is at
// (pos_x, pos_y), addresses a packed multi-frame sprite ROM, sequences the
// animation frames and returns a latency-aligned RGB444 pixel plus hit flag.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-low reset
//   pos_x/pos_y  sprite right/bottom edge (exclusive), sampled every cycle
//   h_cnt/v_cnt  scan column/row
//   mode         0 STATIC, 1 ANIM, 2 DEAD, 3 HOLD
//   flip_h       horizontal mirror (only with SPRITE_MIRROR_EN defined)
//   rom          sprite ROM bus (master side): rom_addr out, rom_data in
//   pixel        RGB444 result, BG_COLOR on a miss or transparent texel
//   hit          sprite opaque at this pixel
// Latency from h_cnt/v_cnt to pixel/hit is 2+ROM_LAT cycles.
//
// Optional feature: define SPRITE_MIRROR_EN to add the flip_h input.
// ---------------------------------------------------------------------------
module gen_pic_sprite #(
  parameter int          SPR_W       = 44,
  parameter int          SPR_H       = 49,
  parameter int          FRAMES      = 2,
  parameter int          FRAME_TICKS = 4000000,
  parameter int          ROM_LAT     = 1,
  parameter int          ADDR_W      = 17,
  parameter logic [11:0] BG_COLOR    = 12'hFFF,
  parameter logic [11:0] KEY_COLOR   = 12'hFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  input  logic [1:0]            mode,
`ifdef SPRITE_MIRROR_EN
  input  logic                  flip_h,
`endif
  gen_pic_sprite_if.master      rom,
  output logic [11:0]           pixel,
  output logic                  hit
);

  localparam int TW       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FW       = $clog2(FRAMES + 1);
  localparam int FRAME_SZ = SPR_W * SPR_H;

  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [FW-1:0] FRAME_DEAD = FW'(FRAMES);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ANIM   = 2'd1,
    MODE_DEAD   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  mode_e                    mode_s;
  logic [TW-1:0]            tick_r, tick_nxt_s;
  logic [FW-1:0]            frame_next_r, frame_nxt_s;
  logic [FW-1:0]            frame_disp_r, frame_sel_s;
  logic                     at_origin_s;

  logic signed [10:0]       hs_s, vs_s, px_s, py_s, x0_s, y0_s;
  logic signed [10:0]       col_s, row_s, col_eff_s;
  logic                     inside_s;
  logic [ADDR_W-1:0]        addr_s;
  logic [ADDR_W-1:0]        rom_addr_r;
  logic [ROM_LAT:0]         in_d_r;

  logic [11:0]              pixel_r, pixel_nxt_s;
  logic                     hit_r, hit_nxt_s;

  assign mode_s      = mode_e'(mode);
  assign at_origin_s = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign rom.rom_addr = rom_addr_r;
  assign pixel       = pixel_r;
  assign hit         = hit_r;

  // Animation sequencer next state; leaving DEAD restarts the cycle at frame 0
  always_comb begin
    tick_nxt_s  = tick_r;
    frame_nxt_s = frame_next_r;
    case (mode_s)
      MODE_STATIC: begin
        tick_nxt_s  = '0;
        frame_nxt_s = '0;
      end
      MODE_ANIM: begin
        if (frame_next_r == FRAME_DEAD) begin
          tick_nxt_s  = '0;
          frame_nxt_s = '0;
        end else if (tick_r == TICK_LAST) begin
          tick_nxt_s  = '0;
          frame_nxt_s = (frame_next_r == FRAME_LAST) ? '0 : frame_next_r + FW'(1);
        end else begin
          tick_nxt_s  = tick_r + TW'(1);
        end
      end
      MODE_DEAD: begin
        frame_nxt_s = FRAME_DEAD;
      end
      MODE_HOLD: begin
        if (frame_next_r == FRAME_DEAD) begin
          tick_nxt_s  = '0;
          frame_nxt_s = '0;
        end else begin
          frame_nxt_s = frame_next_r;
        end
      end
      default: begin
        tick_nxt_s  = tick_r;
        frame_nxt_s = frame_next_r;
      end
    endcase
  end

  // Sprite window test and ROM address; 11-bit signed math lets a negative
  // origin clip instead of wrapping around the 10-bit scan range
  always_comb begin
    hs_s = $signed({1'b0, h_cnt});
    vs_s = $signed({1'b0, v_cnt});
    px_s = $signed({1'b0, pos_x});
    py_s = $signed({1'b0, pos_y});
    x0_s = px_s - $signed(11'(SPR_W));
    y0_s = py_s - $signed(11'(SPR_H));
    inside_s = (hs_s >= x0_s) && (hs_s < px_s) && (vs_s >= y0_s) && (vs_s < py_s);
    col_s = hs_s - x0_s;
    row_s = vs_s - y0_s;
`ifdef SPRITE_MIRROR_EN
    col_eff_s = flip_h ? ($signed(11'(SPR_W - 1)) - col_s) : col_s;
`else
    col_eff_s = col_s;
`endif
    // The new frame takes effect on the (0,0) pixel itself, so a screen never mixes frames
    frame_sel_s = at_origin_s ? frame_next_r : frame_disp_r;
    addr_s = ADDR_W'(frame_sel_s) * ADDR_W'(FRAME_SZ)
           + ADDR_W'($unsigned(row_s)) * ADDR_W'(SPR_W)
           + ADDR_W'($unsigned(col_eff_s));
  end

  // Output pixel selection from the ROM word and the aligned inside flag
  always_comb begin
    hit_nxt_s   = in_d_r[ROM_LAT] && (rom.rom_data != KEY_COLOR);
    pixel_nxt_s = hit_nxt_s ? rom.rom_data : BG_COLOR;
  end

  // Sequencer counters and tear-free display frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_r       <= '0;
      frame_next_r <= '0;
      frame_disp_r <= '0;
    end else begin
      tick_r       <= tick_nxt_s;
      frame_next_r <= frame_nxt_s;
      if (at_origin_s) begin
        frame_disp_r <= frame_next_r;
      end else begin
        frame_disp_r <= frame_disp_r;
      end
    end
  end

  // Stage 1 address register (held on a miss) and inside-flag delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_r <= '0;
      in_d_r     <= '0;
    end else begin
      if (inside_s) begin
        rom_addr_r <= addr_s;
      end else begin
        rom_addr_r <= rom_addr_r;
      end
      in_d_r <= {in_d_r[ROM_LAT-1:0], inside_s};
    end
  end

  // Final registered pixel and hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_r <= BG_COLOR;
      hit_r   <= 1'b0;
    end else begin
      pixel_r <= pixel_nxt_s;
      hit_r   <= hit_nxt_s;
    end
  end

endmodule

// File: doc/gen_pic_sprite.md
# gen_pic_sprite

Parametrised sprite pixel generator for the VGA path, replacing per-pose hard-wired sprite logic with a single engine. It checks whether the current scan position (h_cnt, v_cnt) lies inside a W×H sprite anchored at (pos_x, pos_y) and computes the address into a packed multi-frame sprite ROM. It runs an internal animation frame sequencer and returns a latency-aligned 12-bit RGB pixel with a hit flag to the screen compositor.

## Interface
- SPR_W, 44, sprite width in pixels
- SPR_H, 49, sprite height in pixels
- FRAMES, 2, animation frames; the ROM also holds one extra "dead" frame at index FRAMES
- FRAME_TICKS, 4000000, clk cycles per animation frame (≥2)
- ROM_LAT, 1, ROM read latency in cycles (1–3)
- ADDR_W, 17, ROM address width
- BG_COLOR, 12'hFFF, pixel value output on a miss
- KEY_COLOR, 12'hFFF, ROM value treated as transparent

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-low reset
- pos_x  in  10  sprite right edge (exclusive)
- pos_y  in  10  sprite bottom edge (exclusive)
- h_cnt  in  10  scan column
- v_cnt  in  10  scan row
- mode  in  2  0 STATIC, 1 ANIM, 2 DEAD, 3 HOLD
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  12  ROM read data, ROM_LAT cycles after rom_addr
- pixel  out  12  RGB444 result
- hit  out  1  sprite opaque at this pixel

## Operation
- Inside test: pos_x−SPR_W ≤ h_cnt < pos_x and pos_y−SPR_H ≤ v_cnt < pos_y.
- Compute in 11-bit signed arithmetic. Rows and columns with a negative origin (pos below SPR_W/SPR_H) clip and never wrap.
- Address: rom_addr = frame_disp·SPR_W·SPR_H + row·SPR_W + col, where row = v_cnt−(pos_y−SPR_H) and col = h_cnt−(pos_x−SPR_W). On a miss, rom_addr holds its previous value.
- Sequencer: tick counter (0..FRAME_TICKS−1) and frame_next (0..FRAMES−1).
  - ANIM: count. On tick==FRAME_TICKS−1, reset tick to 0 and set frame_next to (frame_next+1) mod FRAMES.
  - STATIC: tick=0, frame_next=0.
  - DEAD: tick frozen, frame_next=FRAMES.
  - HOLD: tick and frame_next frozen.
  - Leaving DEAD for ANIM or HOLD restarts from frame 0.
- Tear-free update: frame_disp ← frame_next only on the cycle where h_cnt==0 and v_cnt==0. A mode change mid-frame becomes visible from the next screen.
- Output: hit = inside (delayed) && rom_data≠KEY_COLOR. pixel = hit ? rom_data : BG_COLOR.

## Timing
- Stage 1: inside and address registered into rom_addr.
- Stages 2..1+ROM_LAT: ROM read. The inside flag is shifted alongside.
- Stage 2+ROM_LAT: pixel and hit registered.
- Total latency from h_cnt/v_cnt to pixel/hit is 2+ROM_LAT cycles. The compositor delays sync signals by the same amount.
- pos_x, pos_y and mode are sampled every cycle. The sprite position is not shadowed, so callers update it during blanking.
- Reset (any time, asynchronous) sets:
  - rom_addr=0, pixel=BG_COLOR, hit=0
  - tick=0, frame_next=0, frame_disp=0
  - all delay-line inside flags cleared
- The first valid pixel appears 2+ROM_LAT cycles after rst deasserts.

## Configuration
- SPRITE_MIRROR_EN:
  - Defined: adds input flip_h (1 bit), sampled with h_cnt. When flip_h=1, col is replaced by SPR_W−1−col, drawing a mirrored sprite with no extra ROM.
  - Undefined: no flip_h port, and col is always used unmirrored.

## Test plan
- Defaults, ROM_LAT=1, mode=STATIC, pos=(80,298), scan h=36,v=249 → after 3 cycles rom_addr was 0 and hit=1 with pixel=rom_data; at h=80 → hit=0, pixel=12'hFFF.
- ANIM, FRAME_TICKS=4, FRAMES=2 → frame_next toggles every 4 cycles; frame_disp changes only at (0,0), giving base address 0 then 2156.
- DEAD asserted mid-screen → frame 0/1 continues until next (0,0), then rom_addr base is 4312; return to ANIM restarts at frame 0.
- pos=(20,10) → columns 0–23 and rows 0–38 never hit, no address wraps; visible region maps to col≥24, row≥39.
- rom_data=KEY_COLOR inside sprite → hit=0, pixel=BG_COLOR; rst pulsed low mid-line → pixel=BG_COLOR and hit=0 immediately, and tick and frame registers are 0.
- With SPRITE_MIRROR_EN and flip_h=1, scan h=36 at the top row → rom_addr=43.
